// File: rtl/clk_lock_sequencer.sv
// Power-up and relock sequencer for a PLL feeding a DCM: pulses each reset in turn,
// waits for the locks, settles, then reports clocks_ready and counts relocks and timeouts.
module clk_lock_sequencer #(
  parameter int CW            = 20,
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 65535,
  parameter int SETTLE_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_lock,
  input  logic       dcm_lock,
  output logic       pll_rst,
  output logic       dcm_rst,
  output logic       clocks_ready,
  output logic [2:0] state,
  output logic [7:0] relock_count,
  output logic [7:0] timeout_count
);

  typedef enum logic [2:0] {
    S_PLL_RST  = 3'd0,
    S_PLL_WAIT = 3'd1,
    S_DCM_RST  = 3'd2,
    S_DCM_WAIT = 3'd3,
    S_SETTLE   = 3'd4,
    S_RUN      = 3'd5
  } state_e;

  localparam logic [CW-1:0] RST_LAST    = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] LOCK_LAST   = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [7:0]    CNT_MAX     = 8'hFF;

  state_e        state_q, state_d;
  logic [CW-1:0] timer_q, timer_d;
  logic          pll_meta_q, pll_s_q;
  logic          dcm_meta_q, dcm_s_q;
  logic          pll_rst_q, dcm_rst_q, ready_q;
  logic [7:0]    relock_q, timeout_q;
  logic          relock_inc, timeout_inc;

  // Next-state decode; within each state the checks are ordered pll loss,
  // dcm loss, then timer expiry so the higher-priority event always wins.
  always_comb begin
    // NOTE: every signal gets a default here so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d     = state_q;
    relock_inc  = 1'b0;
    timeout_inc = 1'b0;
    case (state_q)
      S_PLL_RST: begin
        if (timer_q == RST_LAST) state_d = S_PLL_WAIT;
      end
      S_PLL_WAIT: begin
        if (pll_s_q) begin
          state_d = S_DCM_RST;
        end else if (timer_q == LOCK_LAST) begin
          state_d     = S_PLL_RST;
          timeout_inc = 1'b1;
        end
      end
      S_DCM_RST: begin
        if (!pll_s_q)                state_d = S_PLL_RST;
        else if (timer_q == RST_LAST) state_d = S_DCM_WAIT;
      end
      S_DCM_WAIT: begin
        if (!pll_s_q) begin
          state_d = S_PLL_RST;
        end else if (dcm_s_q) begin
          state_d = S_SETTLE;
        end else if (timer_q == LOCK_LAST) begin
          // Only the DCM stage is retried; the PLL is still locked.
          state_d     = S_DCM_RST;
          timeout_inc = 1'b1;
        end
      end
      S_SETTLE: begin
        if (!pll_s_q)                    state_d = S_PLL_RST;
        else if (!dcm_s_q)               state_d = S_DCM_RST;
        else if (timer_q == SETTLE_LAST) state_d = S_RUN;
      end
      S_RUN: begin
        // A simultaneous loss of both locks is one relock event, not two.
        if (!pll_s_q) begin
          state_d    = S_PLL_RST;
          relock_inc = 1'b1;
        end else if (!dcm_s_q) begin
          state_d    = S_DCM_RST;
          relock_inc = 1'b1;
        end
      end
      default: state_d = S_PLL_RST;
    endcase
  end

  // RUN is untimed, so its timer simply holds at the zero it entered with.
  always_comb begin
    if (state_d != state_q)   timer_d = '0;
    else if (state_q == S_RUN) timer_d = timer_q;
    else                       timer_d = timer_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: sequential state is only ever written with non-blocking
      // assignments so every register samples pre-edge values.
      pll_meta_q <= 1'b0;
      pll_s_q    <= 1'b0;
      dcm_meta_q <= 1'b0;
      dcm_s_q    <= 1'b0;
      state_q    <= S_PLL_RST;
      timer_q    <= '0;
      pll_rst_q  <= 1'b1;
      dcm_rst_q  <= 1'b1;
      ready_q    <= 1'b0;
      relock_q   <= '0;
      timeout_q  <= '0;
    end else begin
      pll_meta_q <= pll_lock;
      pll_s_q    <= pll_meta_q;
      dcm_meta_q <= dcm_lock;
      dcm_s_q    <= dcm_meta_q;
      state_q    <= state_d;
      timer_q    <= timer_d;
      // Outputs are decoded from the current state register, so they trail
      // the state by one cycle and are glitch-free.
      pll_rst_q  <= (state_q == S_PLL_RST);
      dcm_rst_q  <= (state_q <= S_DCM_RST);
      ready_q    <= (state_q == S_RUN);
      if (relock_inc && relock_q != CNT_MAX)   relock_q  <= relock_q + 8'd1;
      if (timeout_inc && timeout_q != CNT_MAX) timeout_q <= timeout_q + 8'd1;
    end
  end

  assign pll_rst       = pll_rst_q;
  assign dcm_rst       = dcm_rst_q;
  assign clocks_ready  = ready_q;
  assign state         = state_q;
  assign relock_count  = relock_q;
  assign timeout_count = timeout_q;

endmodule

// File: tb/tb_clk_lock_sequencer.sv
// Directed bench for clk_lock_sequencer: stimulus schedules hand-computed expectations
// by cycle into a scoreboard; a negedge monitor pops and compares them.
module tb_clk_lock_sequencer;

  logic       clk = 1'b0;
  logic       rst, pll_lock, dcm_lock;
  logic       pll_rst, dcm_rst, clocks_ready;
  logic [2:0] state;
  logic [7:0] relock_count, timeout_count;

  clk_lock_sequencer #(
    .CW(20), .RST_CYCLES(4), .LOCK_TIMEOUT(100), .SETTLE_CYCLES(8)
  ) dut (
    .clk(clk), .rst(rst), .pll_lock(pll_lock), .dcm_lock(dcm_lock),
    .pll_rst(pll_rst), .dcm_rst(dcm_rst), .clocks_ready(clocks_ready),
    .state(state), .relock_count(relock_count), .timeout_count(timeout_count)
  );

  always #5 clk = ~clk;

  typedef enum {F_STATE, F_PLL_RST, F_DCM_RST, F_READY, F_RC, F_TC} field_e;
  typedef struct {
    int     t;
    field_e f;
    int     val;
    string  name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int actual(input field_e f);
    case (f)
      F_STATE:   return int'(state);
      F_PLL_RST: return int'(pll_rst);
      F_DCM_RST: return int'(dcm_rst);
      F_READY:   return int'(clocks_ready);
      F_RC:      return int'(relock_count);
      default:   return int'(timeout_count);
    endcase
  endfunction

  task automatic check(input string name, input int act, input int exp, input int at);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0d, expected %0d", name, at, act, exp);
    end
  endtask

  // Sorted insert keeps the scoreboard ordered by sample cycle.
  task automatic ex(input int t, input field_e f, input int val, input string name);
    exp_t e;
    int   i;
    e.t = t; e.f = f; e.val = val; e.name = name;
    i = sb.size();
    while (i > 0 && sb[i-1].t > t) i--;
    sb.insert(i, e);
  endtask

  task automatic ex_all(input int t, input int st, input int pr, input int dr,
                        input int rdy, input int rc, input int tc, input string tag);
    ex(t, F_STATE,   st,  {tag, "_state"});
    ex(t, F_PLL_RST, pr,  {tag, "_pll_rst"});
    ex(t, F_DCM_RST, dr,  {tag, "_dcm_rst"});
    ex(t, F_READY,   rdy, {tag, "_ready"});
    ex(t, F_RC,      rc,  {tag, "_relock"});
    ex(t, F_TC,      tc,  {tag, "_timeout"});
  endtask

  // Returns #1 after the posedge that brings cyc to t.
  task automatic go(input int t);
    if (cyc > t) begin
      n_checks++; n_fail++;
      $display("FAIL schedule: cycle %0d already passed (now %0d)", t, cyc);
    end
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: samples outputs on the falling edge, away from the active edge.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].t <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      if (e.t < cyc) begin
        n_checks++; n_fail++;
        $display("FAIL %s: sample cycle %0d missed, now %0d", e.name, e.t, cyc);
      end else begin
        check(e.name, actual(e.f), e.val, cyc);
      end
    end
  end

  initial begin
    rst = 1'b1; pll_lock = 1'b0; dcm_lock = 1'b0;

    // Nominal bring-up: rst released after edge 2.
    ex_all(2, 0, 1, 1, 0, 0, 0, "t1_reset");
    for (int c = 3; c <= 6; c++) ex(c, F_PLL_RST, 1, "t1_pll_rst_held");
    for (int c = 3; c <= 5; c++) ex(c, F_STATE, 0, "t1_in_pll_rst");
    ex(6,  F_STATE,   1, "t1_pll_wait");
    ex(7,  F_PLL_RST, 0, "t1_pll_rst_fall");
    ex(14, F_STATE,   1, "t1_still_pll_wait");
    ex(15, F_STATE,   2, "t1_dcm_rst");
    ex(19, F_STATE,   3, "t1_dcm_wait");
    ex(19, F_DCM_RST, 1, "t1_dcm_rst_last");
    ex(20, F_DCM_RST, 0, "t1_dcm_rst_fall");
    ex(28, F_STATE,   4, "t1_settle");
    ex(35, F_STATE,   4, "t1_settle_last");
    ex(36, F_STATE,   5, "t1_run");
    ex(36, F_READY,   0, "t1_ready_lag");
    ex_all(37, 5, 0, 0, 1, 0, 0, "t1_ready");
    go(2);  rst = 1'b0;
    go(12); pll_lock = 1'b1;
    go(25); dcm_lock = 1'b1;

    // PLL lock loss in RUN for one cycle, then full re-sequence.
    ex(43, F_STATE, 0, "t3_to_pll_rst");
    ex(43, F_RC,    1, "t3_relock");
    ex(43, F_READY, 1, "t3_ready_still");
    ex(44, F_READY, 0, "t3_ready_fall");
    ex(44, F_PLL_RST, 1, "t3_pll_rst_rise");
    ex(47, F_STATE, 1, "t3_pll_wait");
    ex(48, F_STATE, 2, "t3_dcm_rst");
    ex(52, F_STATE, 3, "t3_dcm_wait");
    ex(53, F_STATE, 4, "t3_settle");
    ex(61, F_STATE, 5, "t3_run");
    ex_all(62, 5, 0, 0, 1, 1, 0, "t3_back");
    go(40); pll_lock = 1'b0;
    go(41); pll_lock = 1'b1;

    // Simultaneous loss in RUN, then a DCM glitch at SETTLE timer=5.
    ex(68, F_STATE, 0, "t5_to_pll_rst");
    ex(68, F_RC,    2, "t5_relock_once");
    ex_all(69, 0, 1, 1, 0, 2, 0, "t5_after");
    ex(70, F_RC,    2, "t5_relock_stable");
    ex(72, F_STATE, 1, "t5_pll_wait");
    ex(75, F_STATE, 2, "t5_dcm_rst");
    ex(79, F_STATE, 3, "t5_dcm_wait");
    ex(82, F_STATE, 4, "t4_settle");
    ex(89, F_STATE, 4, "t4_settle_t7");
    for (int c = 90; c <= 93; c++) ex(c, F_STATE, 2, "t4_dcm_rst");
    for (int c = 91; c <= 95; c++) ex(c, F_PLL_RST, 0, "t4_pll_rst_low");
    ex(94, F_DCM_RST, 1, "t4_dcm_rst_hi");
    ex(95, F_DCM_RST, 0, "t4_dcm_rst_fall");
    ex(94, F_STATE, 3, "t4_dcm_wait");
    ex(95, F_STATE, 4, "t4_resettle");
    ex(102, F_STATE, 4, "t4_settle_last");
    ex(103, F_STATE, 5, "t4_run");
    ex_all(104, 5, 0, 0, 1, 2, 0, "t4_back");
    go(65); pll_lock = 1'b0; dcm_lock = 1'b0;
    go(72); pll_lock = 1'b1;
    go(79); dcm_lock = 1'b1;
    go(87); dcm_lock = 1'b0;
    go(88); dcm_lock = 1'b1;

    // DCM loss in RUN held long enough to time out DCM_WAIT once.
    ex(109, F_STATE, 2, "t7_to_dcm_rst");
    ex(109, F_RC,    3, "t7_relock");
    ex(110, F_PLL_RST, 0, "t7_pll_rst_low");
    ex(113, F_STATE, 3, "t7_dcm_wait");
    ex(212, F_STATE, 3, "t7_wait_last");
    ex(212, F_TC,    0, "t7_no_timeout_yet");
    ex(213, F_STATE, 2, "t7_retry_dcm");
    ex(213, F_TC,    1, "t7_timeout");
    ex(214, F_DCM_RST, 1, "t7_dcm_rst_again");
    ex(214, F_PLL_RST, 0, "t7_pll_rst_still_low");
    ex(217, F_STATE, 3, "t7_dcm_wait2");
    go(106); dcm_lock = 1'b0;

    // Reset pulse in DCM_WAIT with nonzero counts.
    ex(220, F_RC, 3, "t6a_pre_relock");
    ex(220, F_TC, 1, "t6a_pre_timeout");
    ex_all(221, 0, 1, 1, 0, 0, 0, "t6a_reset");
    go(220); rst = 1'b1; pll_lock = 1'b0;
    go(221); rst = 1'b0;

    // PLL never locks: PLL_RST(4)/PLL_WAIT(100) loop, timeout saturates.
    ex(225, F_STATE, 1, "t2_pll_wait");
    for (int k = 1; k <= 256; k++) begin
      int base;
      base = 221 + 104 * k;
      ex(base - 1,  F_STATE,   1, "t2_wait_last");
      ex(base - 1,  F_TC,      (k - 1 > 255) ? 255 : k - 1, "t2_tc_before");
      ex(base,      F_STATE,   0, "t2_retry");
      ex(base,      F_TC,      (k > 255) ? 255 : k, "t2_tc");
      ex(base + 4,  F_STATE,   1, "t2_wait_again");
      ex(base + 50, F_DCM_RST, 1, "t2_dcm_rst_held");
    end

    // Bring-up from saturated timeouts, then reset pulse in RUN.
    go(26900);
    ex(26903, F_STATE, 2, "t6b_dcm_rst");
    ex(26907, F_STATE, 3, "t6b_dcm_wait");
    ex(26908, F_STATE, 4, "t6b_settle");
    ex_all(26920, 5, 0, 0, 1, 0, 255, "t6b_run");
    ex_all(26921, 0, 1, 1, 0, 0, 0, "t6b_reset");
    ex(26922, F_STATE,   0, "t6b_hold_pll_rst");
    ex(26922, F_PLL_RST, 1, "t6b_pll_rst_hi");
    pll_lock = 1'b1; dcm_lock = 1'b1;
    go(26920); rst = 1'b1;
    go(26921); rst = 1'b0;

    go(26925);
    check("scoreboard_drained", sb.size(), 0, cyc);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
